dm_banked_ctrl: RTL and testbench
=================================

// Module: dm_banked_ctrl
// PURPOSE
//  Parametrised successor data memory for the MEM stage. Adds a valid/ready request port,
//  configurable read latency, in-block sub-word store steering, load sign/zero extension,
//  misalignment/range error reporting, and a post-reset hardware clear sequence.
//  Sits between the MEM pipeline register and the W stage; one single-port word array.
// PARAMETERS
//  ADDR_W     12       word-address width; DEPTH = 2**ADDR_W 32-bit words
//  LATENCY    1        request-accept to rsp_valid, in cycles; legal 1..4
//  BASE_ADDR  32'h0    byte address of word 0; accesses outside [BASE, BASE+4*DEPTH) error
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   block can accept; transfer on req_valid & req_ready at posedge
//  req_we     in   1   1 = store, 0 = load
//  req_size   in   2   0 byte, 1 half, 2 word, 3 reserved (error)
//  req_sign   in   1   load sign-extend (1) / zero-extend (0); ignored on stores
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  req_pc     in   32  PC of the instruction (trace only)
//  rsp_valid  out  1   response strobe, one cycle per accepted request
//  rsp_rdata  out  32  extended load data; 0 for stores and errors
//  rsp_err    out  1   misaligned, out of range, or size==3
//  init_busy  out  1   clear sequence in progress
// BEHAVIOUR
//  - Reset (reset=0): state<=INIT, clear index<=0, response pipe flushed; outputs
//    req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1. Reset mid-operation
//    discards in-flight responses (no rsp_valid for them) and restarts INIT.
//  - FSM INIT: writes 0 to word[idx] each cycle, idx++; at idx==DEPTH-1 -> RUN next cycle.
//    INIT lasts exactly DEPTH cycles after reset release; req_ready=0, init_busy=1.
//  - FSM RUN: req_ready=1 every cycle (no response back-pressure); one request per cycle.
//  - Store commits at the accept edge; a load accepted on the following cycle sees it.
//  - Load read at accept edge; rsp_valid asserted exactly LATENCY cycles after accept,
//    fully pipelined (back-to-back accepts give back-to-back responses, in order).
//  - Stores also return rsp_valid after LATENCY (ack), rsp_rdata=0.
//  - Errors: half with addr[0]=1, word with addr[1:0]!=0, size==3, or addr out of range
//    -> no array write, rsp_err=1, rsp_rdata=0, same latency.
//  - Store steering: byte -> lane addr[1:0] gets wdata[7:0]; half -> lanes {addr[1],1/0}
//    get wdata[15:0]; word -> all lanes. Unselected lanes keep old contents.
//  - Load extraction: lane selected by addr[1:0]/addr[1]; extend per req_sign to 32 bits.
//  - Word index = (req_addr - BASE_ADDR) >> 2, truncated to ADDR_W after range check.
// CONFIGURATION
//  DM_TRACE_EN defined: every committed store prints
//    "%d@%h: *%h <= %h" ($time, req_pc, req_addr, merged 32-bit word) at the commit edge.
//  Undefined: no $display; identical cycle behaviour. INIT writes are never traced.
// STRUCTURE
//  Shared package dm_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD encodings, FSM state
//  encodings ST_INIT/ST_RUN, LATENCY_MAX=4.
//  Sub-module dm_lane_align (combinational): store byte-enable + data steering and load
//  lane extraction/extension; top holds array, FSM, clear counter, response shift pipe.
// TESTING
//  1 Release reset, DEPTH=16: init_busy high exactly 16 cycles, then req_ready=1; load
//    every word -> rdata 0, err 0.
//  2 sw 0x80FF7F01 @0x10; lb @0x10 sign -> 0x00000001; lb @0x13 sign -> 0xFFFFFF80;
//    lbu @0x13 -> 0x00000080; lh @0x12 sign -> 0xFFFF80FF; lhu -> 0x000080FF.
//  3 sb 0xAB @0x21 over word 0x11223344 -> lw @0x20 = 0x1122AB44; sh 0xBEEF @0x22
//    -> 0xBEEFAB44.
//  4 sh @0x01, sw @0x06, size=3, addr=BASE+4*DEPTH -> rsp_err=1, rdata 0, memory unchanged.
//  5 LATENCY=3: 4 back-to-back loads -> 4 consecutive rsp_valid starting 3 cycles after
//    first accept, in order; assert reset mid-stream -> no further rsp_valid, INIT restarts.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the banked data memory controller.
package dm_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int LATENCY_MAX = 4;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  // The reserved size encoding is reported as an alignment error.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      SIZE_WORD: return lo != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_banked_ctrl_if.sv
// Request/response bus of the data memory controller.
interface dm_banked_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/dm_lane_align.sv
// Byte-lane steering for stores and lane extraction with sign/zero extension for loads.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lo,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic [31:0] rsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign rsh = rword >> {lo, 3'b000};
  assign b   = rsh[7:0];
  assign h   = lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be    = 4'b0000;
    wlane = wdata;
    rext  = '0;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << lo;
        wlane = {4{wdata[7:0]}};
        rext  = {{24{sign & b[7]}}, b};
      end
      SIZE_HALF: begin
        be    = lo[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
        rext  = {{16{sign & h[15]}}, h};
      end
      SIZE_WORD: begin
        be    = 4'b1111;
        wlane = wdata;
        rext  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_banked_ctrl.sv
// Single-port data memory with post-reset clear, sub-word access and pipelined responses.
// Define DM_TRACE_EN to print every committed store.
module dm_banked_ctrl
  import dm_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic            clk,
  input  logic            reset,
  dm_banked_ctrl_if.slave bus
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [33:0] SPAN  = 34'd4 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  state_e            state;
  logic [ADDR_W-1:0] idx;
  logic              rdy_q, busy_q;

  logic              acc, in_range, err, st_wr;
  logic [31:0]       off, rword, wlane, rext, merged;
  logic [ADDR_W-1:0] widx;
  logic [3:0]        be;
  rsp_t              rsp_in;

  logic [LATENCY-1:0] vld_pipe;
  rsp_t               rsp_pipe [LATENCY];

  assign acc      = bus.req_valid & rdy_q;
  assign off      = bus.req_addr - BASE_ADDR;
  assign in_range = (bus.req_addr >= BASE_ADDR) && ({2'b00, off} < SPAN);
  assign err      = ~in_range | misaligned(bus.req_size, bus.req_addr[1:0]);
  assign widx     = off[ADDR_W+1:2];
  assign rword    = mem[widx];
  assign st_wr    = acc & bus.req_we & ~err;

  dm_lane_align u_align (
    .size  (bus.req_size),
    .lo    (bus.req_addr[1:0]),
    .sign  (bus.req_sign),
    .wdata (bus.req_wdata),
    .rword (rword),
    .be    (be),
    .wlane (wlane),
    .rext  (rext)
  );

  for (genvar l = 0; l < 4; l++) begin : g_lane
    assign merged[8*l +: 8] = be[l] ? wlane[8*l +: 8] : rword[8*l +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_INIT;
      idx    <= '0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          idx <= idx + 1'b1;
          if (&idx) begin
            state  <= ST_RUN;
            rdy_q  <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        default: begin
          rdy_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // The array has no reset; the clear sequence zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) mem[idx] <= '0;
    else if (st_wr)       mem[widx] <= merged;
  end

  assign rsp_in.err  = err;
  assign rsp_in.data = (err | bus.req_we) ? 32'h0 : rext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) rsp_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= acc;
      rsp_pipe[0] <= acc ? rsp_in : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        rsp_pipe[i] <= rsp_pipe[i-1];
      end
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.init_busy = busy_q;
  assign bus.rsp_valid = vld_pipe[LATENCY-1];
  assign bus.rsp_rdata = rsp_pipe[LATENCY-1].data;
  assign bus.rsp_err   = rsp_pipe[LATENCY-1].err;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (st_wr) $display("%d@%h: *%h <= %h", $time, bus.req_pc, bus.req_addr, merged);
  end
`endif

endmodule

// File: tb/tb_dm_banked_ctrl.sv
// Self-checking bench: vector table plus scoreboard of expected responses.
module tb_dm_banked_ctrl;
  import dm_pkg::*;

  localparam int          ADDR_W = 4;
  localparam int          DEPTH  = 16;
  localparam int          LAT    = 3;
  localparam logic [31:0] BASE   = 32'h0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          id;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq [$];
  vec_t tbl [31];

  dm_banked_ctrl_if bus ();

  dm_banked_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sign,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("rdata[%0d]", e.id), bus.rsp_rdata, e.rdata);
        chk($sformatf("err[%0d]", e.id), 32'(bus.rsp_err), 32'(e.err));
        chk($sformatf("latency[%0d]", e.id), 32'(cyc - e.acc_cyc), 32'(LAT - 1));
      end
    end
  end

  // Called #1 after a posedge; the request is accepted at the next posedge.
  task automatic issue(input vec_t v, input int id);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_size  = v.size;
    bus.req_sign  = v.sign;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_pc    = 32'h1000 + 32'(4 * id);
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.acc_cyc = cyc + 1; e.id = id;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    chk(name, 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Called at the negedge where reset is released.
  task automatic init_wait(input string name);
    int n;
    int bad_rdy;
    n = 0;
    bad_rdy = 0;
    while (bus.init_busy === 1'b1 && n < 100) begin
      if (bus.req_ready !== 1'b0) bad_rdy++;
      n++;
      @(negedge clk);
    end
    chk({name, "_cycles"}, 32'(n), 32'(DEPTH));
    chk({name, "_ready_low"}, 32'(bad_rdy), 32'd0);
    chk({name, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_sign = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_pc = '0;

    tbl[0]  = mk(1, SIZE_WORD, 0, 32'h10, 32'h80FF7F01, 32'h0, 0);
    tbl[1]  = mk(0, SIZE_BYTE, 1, 32'h10, 32'h0, 32'h00000001, 0);
    tbl[2]  = mk(0, SIZE_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    tbl[3]  = mk(0, SIZE_BYTE, 0, 32'h13, 32'h0, 32'h00000080, 0);
    tbl[4]  = mk(0, SIZE_HALF, 1, 32'h12, 32'h0, 32'hFFFF80FF, 0);
    tbl[5]  = mk(0, SIZE_HALF, 0, 32'h12, 32'h0, 32'h000080FF, 0);
    tbl[6]  = mk(1, SIZE_WORD, 0, 32'h20, 32'h11223344, 32'h0, 0);
    tbl[7]  = mk(1, SIZE_BYTE, 0, 32'h21, 32'hFFFFFFAB, 32'h0, 0);
    tbl[8]  = mk(0, SIZE_WORD, 0, 32'h20, 32'h0, 32'h1122AB44, 0);
    tbl[9]  = mk(1, SIZE_HALF, 0, 32'h22, 32'h1234BEEF, 32'h0, 0);
    tbl[10] = mk(0, SIZE_WORD, 0, 32'h20, 32'h0, 32'hBEEFAB44, 0);
    tbl[11] = mk(1, SIZE_HALF, 0, 32'h01, 32'h0000FFFF, 32'h0, 1);
    tbl[12] = mk(1, SIZE_WORD, 0, 32'h06, 32'hFFFFFFFF, 32'h0, 1);
    tbl[13] = mk(0, SIZE_RSVD, 0, 32'h00, 32'h0, 32'h0, 1);
    tbl[14] = mk(1, SIZE_WORD, 0, 32'h40, 32'h12345678, 32'h0, 1);
    tbl[15] = mk(1, SIZE_RSVD, 0, 32'h0C, 32'hFFFFFFFF, 32'h0, 1);
    tbl[16] = mk(0, SIZE_WORD, 0, 32'h00, 32'h0, 32'h0, 0);
    tbl[17] = mk(0, SIZE_WORD, 0, 32'h04, 32'h0, 32'h0, 0);
    tbl[18] = mk(0, SIZE_WORD, 0, 32'h0C, 32'h0, 32'h0, 0);
    tbl[19] = mk(0, SIZE_WORD, 0, 32'h40, 32'h0, 32'h0, 1);
    tbl[20] = mk(0, SIZE_HALF, 1, 32'h11, 32'h0, 32'h0, 1);
    tbl[21] = mk(0, SIZE_WORD, 0, 32'hFFFFFFFC, 32'h0, 32'h0, 1);
    tbl[22] = mk(0, SIZE_WORD, 0, 32'h3C, 32'h0, 32'h0, 0);
    tbl[23] = mk(1, SIZE_WORD, 0, 32'h3C, 32'hDEADBEEF, 32'h0, 0);
    tbl[24] = mk(0, SIZE_WORD, 0, 32'h3C, 32'h0, 32'hDEADBEEF, 0);
    tbl[25] = mk(0, SIZE_BYTE, 0, 32'h3F, 32'h0, 32'h000000DE, 0);
    tbl[26] = mk(0, SIZE_HALF, 1, 32'h3E, 32'h0, 32'hFFFFDEAD, 0);
    tbl[27] = mk(0, SIZE_BYTE, 1, 32'h3D, 32'h0, 32'hFFFFFFBE, 0);
    tbl[28] = mk(0, SIZE_HALF, 0, 32'h3C, 32'h0, 32'h0000BEEF, 0);
    tbl[29] = mk(0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h80FF7F01, 0);
    tbl[30] = mk(0, SIZE_BYTE, 1, 32'h11, 32'h0, 32'h0000007F, 0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_init_busy", 32'(bus.init_busy), 32'd1);
    reset = 1'b1;
    init_wait("init");

    // Every word reads back zero after the clear
    for (int i = 0; i < DEPTH; i++) issue(mk(0, SIZE_WORD, 0, 32'(4 * i), 32'h0, 32'h0, 0), 100 + i);
    drain("drain_clear");

    for (int i = 0; i < $size(tbl); i++) issue(tbl[i], i);
    drain("drain_table");

    // Back-to-back loads: in-order consecutive responses
    issue(mk(0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h80FF7F01, 0), 200);
    issue(mk(0, SIZE_WORD, 0, 32'h20, 32'h0, 32'hBEEFAB44, 0), 201);
    issue(mk(0, SIZE_WORD, 0, 32'h3C, 32'h0, 32'hDEADBEEF, 0), 202);
    issue(mk(0, SIZE_WORD, 0, 32'h14, 32'h0, 32'h0, 0), 203);
    drain("drain_b2b");

    // Reset while responses are in flight
    issue(mk(0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h80FF7F01, 0), 300);
    issue(mk(0, SIZE_WORD, 0, 32'h20, 32'h0, 32'hBEEFAB44, 0), 301);
    reset = 1'b0;
    sbq.delete();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) cnt++;
    end
    chk("flush_no_rsp", 32'(cnt), 32'd0);
    chk("flush_init_busy", 32'(bus.init_busy), 32'd1);
    chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    init_wait("reinit");
    issue(mk(0, SIZE_WORD, 0, 32'h3C, 32'h0, 32'h0, 0), 400);
    issue(mk(0, SIZE_WORD, 0, 32'h10, 32'h0, 32'h0, 0), 401);
    drain("drain_reinit");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
